scan_doubler: RTL and testbench



---
 rtl/scan_doubler.sv | 142 ++++++++++++++
 tb/tb_scan_doubler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/scan_doubler.sv
// Captures half-rate 8-bit RGB lines into ping-pong buffers and replays each line twice at full rate.
// Latency: one input line. No backpressure: output timing is slaved to in_line_start and the measured period.
module scan_doubler #(
   parameter int LINE_PIXELS = 256,
   parameter int OUT_HSTART  = 48,
   parameter int HSYNC_CLKS  = 46,
   parameter int CNT_W       = 12
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_line_start,
   input  logic       pix_en,
   input  logic       in_valid,
   input  logic [2:0] r_sig,
   input  logic [2:0] g_sig,
   input  logic [1:0] b_sig,
   output logic       out_hsync,
   output logic       out_valid,
   output logic [2:0] out_r,
   output logic [2:0] out_g,
   output logic [1:0] out_b
);

   localparam int AW = $clog2(LINE_PIXELS);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] HS_END    = CNT_W'(HSYNC_CLKS);
   localparam logic [CNT_W-1:0] PORCH_END = CNT_W'(OUT_HSTART - 2);

   typedef enum logic [1:0] {IDLE, SYNC_PORCH, ACTIVE, TAIL} state_t;

   logic [7:0]       mem [0:2*LINE_PIXELS-1];
   logic             wr_bank;
   logic [AW:0]      wr_addr;
   logic [AW:0]      wr_idx;
   logic             wr_en;
   logic [CNT_W-1:0] in_cnt;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] out_cnt;
   logic [CNT_W-1:0] pos;
   logic             period_valid;
   logic             seen_start;
   logic             pv_nxt;
   logic             line_go;
   logic             flush;
   state_t           state;
   logic [AW-1:0]    rd_addr;
   logic [7:0]       rd_dat;
   logic             rd_vld;

   always_comb begin
      half   = period_q >> 1;
      pv_nxt = period_valid;
      if (in_line_start)
         pv_nxt = (in_cnt != CNT_MAX) && seen_start;
      line_go = in_line_start ? pv_nxt : (period_valid && (out_cnt == half));
      flush   = in_line_start || line_go;
      // A pixel coinciding with the line start lands at address 0 of the freshly selected bank.
      wr_idx = {wr_bank, wr_addr[AW-1:0]};
      wr_en  = pix_en && in_valid && !wr_addr[AW] && !rst;
      if (in_line_start) begin
         wr_idx = {~wr_bank, {AW{1'b0}}};
         wr_en  = pix_en && in_valid && !rst;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= {r_sig, g_sig, b_sig};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank      <= 1'b0;
         wr_addr      <= '0;
         in_cnt       <= '0;
         period_q     <= '0;
         period_valid <= 1'b0;
         seen_start   <= 1'b0;
         out_cnt      <= '0;
         pos          <= '0;
         state        <= IDLE;
         rd_addr      <= '0;
         rd_dat       <= '0;
         rd_vld       <= 1'b0;
         out_hsync    <= 1'b0;
         out_valid    <= 1'b0;
         out_r        <= '0;
         out_g        <= '0;
         out_b        <= '0;
      end else begin
         if (in_line_start) begin
            wr_bank      <= ~wr_bank;
            wr_addr      <= {{AW{1'b0}}, pix_en & in_valid};
            period_q     <= in_cnt + 1'b1;
            in_cnt       <= '0;
            period_valid <= pv_nxt;
            seen_start   <= 1'b1;
            out_cnt      <= CNT_W'(1);   // the start cycle itself is count 0
         end else begin
            if (pix_en && in_valid && !wr_addr[AW])
               wr_addr <= wr_addr + 1'b1;
            if (in_cnt != CNT_MAX)
               in_cnt <= in_cnt + 1'b1;
            if (out_cnt != CNT_MAX)
               out_cnt <= out_cnt + 1'b1;
         end

         if (line_go) begin
            state     <= SYNC_PORCH;
            pos       <= CNT_W'(1);
            rd_addr   <= '0;
            out_hsync <= 1'b1;
         end else if (in_line_start) begin
            state     <= IDLE;
            out_hsync <= 1'b0;
         end else begin
            if (pos != CNT_MAX)
               pos <= pos + 1'b1;
            out_hsync <= (state != IDLE) && (pos < HS_END);
            case (state)
               SYNC_PORCH: if (pos == PORCH_END) state <= ACTIVE;
               ACTIVE: begin
                  rd_addr <= rd_addr + 1'b1;
                  if (rd_addr == {AW{1'b1}})
                     state <= TAIL;
               end
               default: state <= state;
            endcase
         end

         // One cycle of buffer read, then a registered output; a line start drops anything in flight.
         rd_dat    <= mem[{~wr_bank, rd_addr}];
         rd_vld    <= (state == ACTIVE) && !flush;
         out_valid <= rd_vld && !flush;
         out_r     <= (rd_vld && !flush) ? rd_dat[7:5] : 3'd0;
         out_g     <= (rd_vld && !flush) ? rd_dat[4:2] : 3'd0;
         out_b     <= (rd_vld && !flush) ? rd_dat[1:0] : 2'd0;
      end
   end

endmodule

// File: tb/tb_scan_doubler.sv
// Randomized bench for scan_doubler: a line-level reference model predicts every output cycle,
// and a monitor compares the DUT against the queued predictions.
module tb_scan_doubler;

   localparam int LP   = 256;
   localparam int HST  = 48;
   localparam int HSW  = 46;
   localparam int SATV = 4095;

   logic       clk = 1'b0;
   logic       rst, in_line_start, pix_en, in_valid;
   logic [2:0] r_sig, g_sig;
   logic [1:0] b_sig;
   logic       out_hsync, out_valid;
   logic [2:0] out_r, out_g;
   logic [1:0] out_b;

   always #5 clk = ~clk;

   scan_doubler dut (
      .clk(clk), .rst(rst), .in_line_start(in_line_start), .pix_en(pix_en),
      .in_valid(in_valid), .r_sig(r_sig), .g_sig(g_sig), .b_sig(b_sig),
      .out_hsync(out_hsync), .out_valid(out_valid),
      .out_r(out_r), .out_g(out_g), .out_b(out_b)
   );

   typedef struct {
      int         cyc;
      bit         hs;
      bit         vl;
      logic [7:0] px;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   tcur   = 0;

   // Reference model state: two line stores plus the timing of the current input line.
   logic [7:0] bank [2][LP];
   bit m_wb;
   int m_wa, m_nst, m_ref, m_s, m_half;
   bit m_pv;

   // Predict the outputs visible in cycle tcur+1 from the inputs applied in cycle tcur.
   task automatic model_step(input bit rs, input bit st, input bit pe, input bit iv,
                             input logic [7:0] d);
      exp_t e;
      int   gap, o, k;
      e.cyc = tcur + 1; e.hs = 0; e.vl = 0; e.px = 8'h00;
      if (rs) begin
         m_wb = 0; m_wa = 0; m_pv = 0; m_nst = 0; m_ref = tcur;
      end else begin
         if (st) begin
            gap = tcur - m_ref;
            m_nst++;
            if (gap - 1 >= SATV) m_pv = 0;
            else if (m_nst >= 2) m_pv = 1;
            m_half = gap / 2;
            m_s = tcur; m_ref = tcur; m_wb = !m_wb; m_wa = 0;
         end
         if (m_pv) begin
            o = (tcur - m_s >= m_half) ? m_s + m_half : m_s;
            k = tcur + 1 - o;
            e.hs = (k >= 1 && k <= HSW);
            if (k >= HST + 1 && k <= HST + LP) begin
               e.vl = 1;
               e.px = bank[!m_wb][k - HST - 1];
            end
         end
         if (pe && iv && m_wa < LP) begin
            bank[m_wb][m_wa] = d;
            m_wa++;
         end
      end
      q.push_back(e);
   endtask

   task automatic cyc1(input bit rs, input bit st, input bit pe, input bit iv,
                       input logic [7:0] d);
      @(posedge clk);
      #1;
      tcur++;
      rst = rs; in_line_start = st; pix_en = pe; in_valid = iv;
      {r_sig, g_sig, b_sig} = d;
      model_step(rs, st, pe, iv, d);
   endtask

   // mode 0: ramp data, every strobe valid; mode 1: random data with random gaps in in_valid.
   task automatic line(input int len, input int npix, input int mode);
      int pi = 0;
      bit pe, iv;
      logic [7:0] d;
      for (int c = 0; c < len; c++) begin
         pe = (c % 2 == 0);
         iv = pe && (pi < npix) && (mode != 1 || $urandom_range(0, 3) != 0);
         d  = (mode == 1) ? 8'($urandom) : 8'(pi);
         cyc1(1'b0, c == 0, pe, iv, d);
         if (iv) pi++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      logic [7:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0 && q[0].cyc == tcur) begin
            e   = q.pop_front();
            act = {out_r, out_g, out_b};
            checks++;
            if (out_hsync !== e.hs || out_valid !== e.vl || act !== e.px) begin
               errors++;
               $display("FAIL out cyc %0d: got hs=%0b vl=%0b rgb=%02h, want hs=%0b vl=%0b rgb=%02h",
                        tcur, out_hsync, out_valid, act, e.hs, e.vl, e.px);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_line_start = 1'b0; pix_en = 1'b0; in_valid = 1'b0;
      r_sig = '0; g_sig = '0; b_sig = '0;

      repeat (4) cyc1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      repeat (2000) cyc1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      repeat (3) line(768, 256, 0);                 // nominal ramp
      repeat (2) line(769, 256, 1);                 // odd period
      line(769, 256, 0);
      line(768, 300, 0);                            // overlong write
      line(768, 256, 1);
      line(148, 256, 1);                            // early start mid-ACTIVE
      line(300, 256, 1);
      repeat (2) line(768, 256, 1);
      line(5000, 256, 1);                           // saturating gap
      repeat (3) line(768, 256, 1);
      repeat (6) line($urandom_range(400, 1000), $urandom_range(100, 300), 1);
      line(768, 256, 1);
      line(400, 256, 1);                            // reset in the middle of a line
      repeat (3) cyc1(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      repeat (3) line(768, 256, 1);
      repeat (5) cyc1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      @(posedge clk);
      #1;
      tcur++;
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d predictions left unchecked, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
